// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one Booth group per cycle,
// 16 accumulate cycles per signed 32x32 product, valid/ready on both sides.

module booth_encoder #(
    parameter int N_BITS = 32
) (
    input  logic [2:0]          booth_group,
    input  logic [4:0]          group_index,
    input  logic [N_BITS-1:0]   multiplicand,
    output logic [2*N_BITS-1:0] partial_product_out
);
    logic [2*N_BITS-1:0] w_a1;
    logic [2*N_BITS-1:0] w_a2;
    logic [2*N_BITS-1:0] w_pp;

    assign w_a1 = {{N_BITS{multiplicand[N_BITS-1]}}, multiplicand};
    assign w_a2 = w_a1 << 1;

    always_comb begin
        w_pp = '0;
        unique case (booth_group)
            3'b001, 3'b010: w_pp = w_a1;
            3'b011:         w_pp = w_a2;
            3'b100:         w_pp = -w_a2;
            3'b101, 3'b110: w_pp = -w_a1;
            default:        w_pp = '0;
        endcase
    end

    assign partial_product_out = w_pp << {group_index, 1'b0};
endmodule

module booth_mul_seq #(
    parameter int N_BITS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_BITS-1:0]   multiplicand,
    input  logic [N_BITS-1:0]   multiplier,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*N_BITS-1:0] product,
    output logic                busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [N_BITS-1:0]   r_a;
    logic [N_BITS-1:0]   r_b;
    logic [2*N_BITS-1:0] r_acc;
    logic [3:0]          r_grp;
    logic [N_BITS:0]     w_bx;
    logic [2:0]          w_group;
    logic [2*N_BITS-1:0] w_pp;
    logic                w_accept;

    // b_q[-1] = 0 is supplied by the appended zero LSB
    assign w_bx     = {r_b, 1'b0};
    assign w_group  = w_bx[{r_grp, 1'b0} +: 3];
    assign w_accept = in_valid && (r_state == S_IDLE);

    booth_encoder #(
        .N_BITS(N_BITS)
    ) u_enc (
        .booth_group        (w_group),
        .group_index        ({1'b0, r_grp}),
        .multiplicand       (r_a),
        .partial_product_out(w_pp)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid) w_next = S_RUN;
            S_RUN:   if (r_grp == 4'd15) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_grp   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= multiplicand;
                r_b   <= multiplier;
                r_acc <= '0;
                r_grp <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= r_acc + w_pp;
                r_grp <= r_grp + 4'd1;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign product   = r_acc;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed cases, backpressure, reset
// mid-run, and randomized operands against a 64-bit signed product model.

module tb_booth_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [63:0] product;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(
        .N_BITS(32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Wait for out_valid after the accept edge; returns cycles elapsed
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            chk("busy_run", {63'b0, busy}, 64'd1);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input int gap, input int hold, input bit toggle);
        int n;
        logic [63:0] exp;
        exp = ref_mul(a, b);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        multiplicand = a;
        multiplier = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_seen", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        multiplicand = $urandom;
        multiplier = $urandom;
        wait_done(n);
        chk("latency", 64'(n), 64'd16);
        chk("product", product, exp);
        chk("busy_done", {63'b0, busy}, 64'd1);
        for (int i = 0; i < hold; i++) begin
            if (toggle) begin
                in_valid = 1'($urandom);
                multiplicand = $urandom;
                multiplier = $urandom;
            end
            @(negedge clk);
            chk("hold_product", product, exp);
            chk("hold_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("released", {61'b0, out_valid, in_ready, busy}, 64'b010);
    endtask

    initial begin
        int n;
        #2;
        chk("rst_flags", {61'b0, in_ready, out_valid, busy}, 64'b100);
        chk("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op(32'd3, 32'd5, 0, 0, 1'b0);
        chk("p_3x5", product, 64'h000000000000000F);
        op(-32'sd7, 32'd6, 1, 0, 1'b0);
        chk("p_m7x6", product, 64'hFFFFFFFFFFFFFFD6);
        op(32'd6, -32'sd7, 0, 0, 1'b0);
        chk("p_6xm7", product, 64'hFFFFFFFFFFFFFFD6);
        op(32'h80000000, 32'h80000000, 0, 0, 1'b0);
        chk("p_min_min", product, 64'h4000000000000000);
        op(32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0);
        chk("p_max_m1", product, 64'hFFFFFFFF80000001);
        op(32'd0, 32'h12345678, 0, 0, 1'b0);
        chk("p_zero", product, 64'd0);

        // backpressure with in_valid and operands toggling
        op(32'h1234, 32'hFEDC_BA98, 0, 5, 1'b1);

        // in_valid together with out_ready in DONE: only output completes
        @(negedge clk);
        in_valid = 1'b1;
        multiplicand = 32'd9;
        multiplier = -32'sd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(n);
        chk("sim_latency", 64'(n), 64'd16);
        chk("sim_first", product, 64'hFFFFFFFFFFFFFFE5);
        in_valid = 1'b1;
        multiplicand = 32'd11;
        multiplier = 32'd13;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("sim_idle", {61'b0, out_valid, in_ready, busy}, 64'b010);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sim_accept", {61'b0, out_valid, in_ready, busy}, 64'b001);
        wait_done(n);
        chk("sim_second", product, 64'd143);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // asynchronous reset in the middle of RUN
        in_valid = 1'b1;
        multiplicand = 32'd5;
        multiplier = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flags", {61'b0, in_ready, out_valid, busy}, 64'b100);
        chk("arst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("arst_no_pulse", {63'b0, out_valid}, 64'd0);
        op(32'd2, 32'd3, 0, 0, 1'b0);
        chk("p_after_rst", product, 64'd6);

        for (int k = 0; k < 1000; k++) begin
            op($urandom, $urandom, $urandom_range(0, 3),
               $urandom_range(0, 3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
